rope_rider_ctrl: RTL
====================

# rope_rider_ctrl

Consumer side of the rope mover's position/speed interface. Latches the player onto the swinging rope on collision and drives the player X position from the rope's `topLeftX` plus a captured grab offset. Releases on a jump request, handing the rope's current speed to the player mover as a launch speed. Sits between the rope mover, the player/rope collision detector and the player mover.

## Interface
Parameters:
- `ROPE_WIDTH`, 32: rope sprite width in pixels; upper bound for the grab offset.
- `COOLDOWN_FRAMES`, 8: frames after release during which `ropeHit` is ignored.
- `GRIP_FRAMES`, 300: frames before a forced release (only with `ROPE_GRIP_TIMEOUT_EN`).

Ports:
- `clk`  in  1: system clock.
- `resetN`  in  1: reset, asynchronous, active-low.
- `startOfFrame`  in  1: one-clk pulse per frame.
- `ropeHit`  in  1: player/rope overlap, level, sampled every clk.
- `jumpKey`  in  1: jump key level.
- `rope_speed`  in  11: rope X speed in 1/64 px per frame, two's complement.
- `ropeTopLeftX`  in  signed 11: rope top-left X in pixels.
- `playerTopLeftX`  in  signed 11: player top-left X in pixels.
- `attached`  out  1: player is riding the rope.
- `riderX`  out  signed 11: player X to force while `attached`.
- `releasePulse`  out  1: one-clk pulse on release.
- `launchSpeed`  out  signed 11: rope speed captured at release, in 1/64 px per frame.

## Operation
- FSM states are FREE, ATTACHED and COOLDOWN. Reset enters FREE.
- **FREE:**
  - When `ropeHit`=1, capture `offset = playerTopLeftX - ropeTopLeftX`, clamped to [0, `ROPE_WIDTH`-1].
  - Clear `jumpReq` and go to ATTACHED.
- **ATTACHED:**
  - Every clk: `riderX <= ropeTopLeftX + offset`, 11-bit signed, with wrap allowed.
  - `jumpReq` is set on a `jumpKey` rising edge (the previous-sample register resets to 1, so a key held through reset does not trigger).
  - On `startOfFrame` with `jumpReq`=1:
    - `launchSpeed <= rope_speed`
    - `releasePulse <= 1` for one clk
    - clear `jumpReq`, load the cooldown counter with `COOLDOWN_FRAMES`, go to COOLDOWN.
- **COOLDOWN:**
  - `ropeHit` is ignored.
  - The counter decrements on each `startOfFrame`; at 0, go to FREE.
  - `COOLDOWN_FRAMES`=0 means go to FREE on the next `startOfFrame`.
- `riderX` holds its last value outside ATTACHED.
- `launchSpeed` holds until the next release.
- Simultaneous events:
  - `ropeHit` and a `jumpKey` edge in the same clk in FREE: attach wins and the edge is discarded.
  - A jump edge and `startOfFrame` in the same clk while ATTACHED: the edge is registered and release happens on the following `startOfFrame`.
- Reset mid-ride: immediate FREE. `attached`=0, `releasePulse`=0.

## Timing
- Reset values: `attached`=0, `riderX`=0, `releasePulse`=0, `launchSpeed`=0, counters=0, `jumpReq`=0.
- All outputs are registered.
- `ropeHit` high at clk N gives `attached`=1 at N+1 and the first `riderX` value at N+2.
- `riderX` follows `ropeTopLeftX` with 1-clk latency.
- Release: `startOfFrame` at clk M gives `attached`=0, `releasePulse`=1 and valid `launchSpeed` at M+1; `releasePulse`=0 at M+2.
- COOLDOWN lasts exactly `COOLDOWN_FRAMES` `startOfFrame` pulses after the release frame.

## Configuration
- `ROPE_GRIP_TIMEOUT_EN` defined:
  - The grip counter loads `GRIP_FRAMES` on attach and decrements each `startOfFrame` while ATTACHED.
  - Reaching 0 forces a release identical to a jump: same `releasePulse`, same `launchSpeed` capture.
  - A jump and a timeout on the same frame produce a single release.
- Not defined: the counter logic is absent, and the player rides indefinitely until a jump.

## Structure
- Shared package `rope_pkg`:
  - state enum `rider_state_t` {FREE, ATTACHED, COOLDOWN}
  - `FIXED_POINT_MULTIPLIER`=64
  - default `ROPE_WIDTH`.
- One sub-module, `frame_down_counter`: a loadable down-counter with enable on `startOfFrame` and a `zero` flag. It is instantiated for cooldown and, under the macro, for grip.

## Test plan
- Reset with `jumpKey`=1, then release reset → `attached`=0, `riderX`=0, no `releasePulse`. Keep `jumpKey` high and assert `ropeHit` → attach, no release.
- `playerTopLeftX`=200, `ropeTopLeftX`=192, `ropeHit` pulse → `attached`=1 next clk. Rope moves to 250 → `riderX`=258 one clk later.
- `playerTopLeftX`=180 and `ropeTopLeftX`=192 → offset clamps to 0. `playerTopLeftX`=240 → offset clamps to 31.
- While attached with `rope_speed`=-20, a `jumpKey` edge, then `startOfFrame` → `releasePulse` for one clk, `launchSpeed`=-20, `attached`=0. `ropeHit` held high → re-attach only after 8 frames.
- `ropeHit` and a `jumpKey` rising edge in the same clk in FREE → attached, no release at the next `startOfFrame`.
- With `ROPE_GRIP_TIMEOUT_EN` and `GRIP_FRAMES`=3 → forced release on the 3rd `startOfFrame` after attach. Without the macro, still attached after 1000 frames.

Source files
------------

// File: rtl/rope_pkg.sv
// rope_pkg: shared rider state type and constants for the rope rider control slice
package rope_pkg;
  typedef enum logic [1:0] {FREE, ATTACHED, COOLDOWN} rider_state_t;
  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int DEFAULT_ROPE_WIDTH = 32;
  localparam int CNT_W = 16;
endpackage

// File: rtl/rope_rider_frame_down_counter.sv
// frame_down_counter: loadable per-frame down-counter that saturates at zero
module frame_down_counter
  import rope_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = (count == '0);
  // load has priority; otherwise count down once per enabled frame, stopping at zero
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) count <= '0;
    else if (load) count <= load_val;
    else if (en && !zero) count <= count - 1'b1;
endmodule

// File: rtl/rope_rider_ctrl.sv
// rope_rider_ctrl: latches the player onto the rope and releases it with the rope speed; ROPE_GRIP_TIMEOUT_EN adds a forced release
module rope_rider_ctrl
  import rope_pkg::*;
#(
  parameter int ROPE_WIDTH      = DEFAULT_ROPE_WIDTH,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int GRIP_FRAMES     = 300
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               ropeHit,
  input  logic               jumpKey,
  input  logic [10:0]        rope_speed,
  input  logic signed [10:0] ropeTopLeftX,
  input  logic signed [10:0] playerTopLeftX,
  output logic               attached,
  output logic signed [10:0] riderX,
  output logic               releasePulse,
  output logic signed [10:0] launchSpeed
);
  localparam logic signed [11:0] OFF_MAX = 12'(ROPE_WIDTH - 1);
  rider_state_t state;
  logic [10:0] offset;
  logic jump_req, jump_prev;
  logic signed [11:0] diff;
  logic [10:0] offset_nxt;
  logic jump_edge, grab, rel, grip_exp;
  logic [CNT_W-1:0] cool_cnt, grip_cnt;
  logic cool_zero, grip_zero;
  assign diff = {playerTopLeftX[10], playerTopLeftX} - {ropeTopLeftX[10], ropeTopLeftX};
  assign offset_nxt = diff[11] ? '0 : (diff > OFF_MAX ? OFF_MAX[10:0] : diff[10:0]);
  assign jump_edge = jumpKey & ~jump_prev;
  assign grab = (state == FREE) && ropeHit;
`ifdef ROPE_GRIP_TIMEOUT_EN
  // a count of one at a frame boundary means this frame empties the grip budget
  assign grip_exp = (grip_cnt[CNT_W-1:1] == '0);
  frame_down_counter #(.W(CNT_W)) u_grip (
    .clk(clk), .resetN(resetN), .load(grab), .load_val(CNT_W'(GRIP_FRAMES)),
    .en(startOfFrame && state == ATTACHED), .count(grip_cnt), .zero(grip_zero)
  );
`else
  assign grip_exp = 1'b0;
  assign grip_cnt = '0;
  assign grip_zero = 1'b1;
`endif
  assign rel = (state == ATTACHED) && startOfFrame && (jump_req || grip_exp);
  frame_down_counter #(.W(CNT_W)) u_cool (
    .clk(clk), .resetN(resetN), .load(rel), .load_val(CNT_W'(COOLDOWN_FRAMES)),
    .en(startOfFrame && state == COOLDOWN), .count(cool_cnt), .zero(cool_zero)
  );
  // rider FSM with registered outputs; jump requests use the previous-cycle flag so an edge on a frame boundary waits a frame
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state        <= FREE;
      attached     <= 1'b0;
      riderX       <= '0;
      releasePulse <= 1'b0;
      launchSpeed  <= '0;
      offset       <= '0;
      jump_req     <= 1'b0;
      jump_prev    <= 1'b1;
    end else begin
      jump_prev    <= jumpKey;
      releasePulse <= 1'b0;
      case (state)
        FREE:
          if (ropeHit) begin
            offset   <= offset_nxt;
            jump_req <= 1'b0;
            attached <= 1'b1;
            state    <= ATTACHED;
          end
        ATTACHED: begin
          riderX <= ropeTopLeftX + offset;
          if (rel) begin
            launchSpeed  <= rope_speed;
            releasePulse <= 1'b1;
            jump_req     <= 1'b0;
            attached     <= 1'b0;
            state        <= COOLDOWN;
          end else if (jump_edge) jump_req <= 1'b1;
        end
        COOLDOWN:
          if (startOfFrame && (cool_cnt[CNT_W-1:1] == '0)) state <= FREE;
        default: state <= FREE;
      endcase
    end
endmodule
